// File: rtl/dec_syndrome_if.sv
// Syndrome stage bus: received beats in, syndromes out.
// Master drives codeword beats, slave returns results.
interface dec_syndrome_if #(
  parameter int M = 8,
  parameter int P = 16,
  parameter int R = 16
);
  logic                  in_valid;
  logic                  in_sop;
  logic [P-1:0][M-1:0]   data_in;
  logic                  syn_valid;
  logic [R-1:0][M-1:0]   syn_data;
  logic                  syn_zero;
  logic                  frm_err;

  modport master (
    output in_valid,
    output in_sop,
    output data_in,
    input  syn_valid,
    input  syn_data,
    input  syn_zero,
    input  frm_err
  );

  modport slave (
    input  in_valid,
    input  in_sop,
    input  data_in,
    output syn_valid,
    output syn_data,
    output syn_zero,
    output frm_err
  );
endinterface

// File: rtl/dec_syndrome.sv
// RS decoder syndrome stage: parallel Horner evaluation
// of S_j = r(alpha^(FCR+j)) at P symbols per beat.
module dec_syndrome #(
  parameter int EGF_ORDER    = 8,
  parameter int EGF_PRIM_POL = 'h11D,
  parameter int RS_COD_LEN   = 255,
  parameter int RS_MES_LEN   = 239,
  parameter int ENC_SYM_NUM  = 16,
  parameter int FCR          = 0
) (
  input logic           clk,
  input logic           rst_n,
  dec_syndrome_if.slave bus
);
  localparam int M     = EGF_ORDER;
  localparam int P     = ENC_SYM_NUM;
  localparam int R     = RS_COD_LEN - RS_MES_LEN;
  localparam int ORD   = (1 << M) - 1;
  localparam int BEATS = (RS_COD_LEN + P - 1) / P;
  localparam int PAD   = (P - RS_COD_LEN % P) % P;
  localparam int CW    = $clog2(BEATS + 1);

  localparam logic [M-1:0] POLY = M'(EGF_PRIM_POL);

  typedef logic [M-1:0]                sym_t;
  typedef logic [R-1:0][M-1:0]         syn_t;
  typedef logic [R-1:0][P-1:0][M-1:0]  tap_t;
  typedef enum logic {IDLE, ACC}       state_t;

  function automatic sym_t mulx(input sym_t a);
    return {a[M-2:0], 1'b0} ^ (POLY & {M{a[M-1]}});
  endfunction

  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t p;
    sym_t x;
    p = '0;
    x = a;
    for (int k = 0; k < M; k++) begin
      if (b[k]) p = p ^ x;
      x = mulx(x);
    end
    return p;
  endfunction

  function automatic sym_t root(input int j);
    sym_t a;
    a = sym_t'(1);
    for (int k = 0; k < (FCR + j) % ORD; k++) a = mulx(a);
    return a;
  endfunction

  function automatic tap_t gen_tap();
    tap_t t;
    sym_t c;
    for (int j = 0; j < R; j++) begin
      c = sym_t'(1);
      for (int i = 0; i < P; i++) begin
        t[j][i] = c;
        c = gf_mul(c, root(j));
      end
    end
    return t;
  endfunction

  function automatic syn_t gen_fb();
    syn_t f;
    sym_t c;
    for (int j = 0; j < R; j++) begin
      c = sym_t'(1);
      for (int i = 0; i < P; i++) c = gf_mul(c, root(j));
      f[j] = c;
    end
    return f;
  endfunction

  localparam tap_t TAP = gen_tap();
  localparam syn_t FB  = gen_fb();

  state_t        state;
  logic [CW-1:0] cnt;
  syn_t          acc;
  syn_t          beat_sum;
  syn_t          acc_next;
  syn_t          syn_q;
  logic          valid_q;
  logic          zero_q;
  logic          ferr_q;
  logic          last_beat;

  assign last_beat = (cnt == CW'(BEATS - 1));

  // Beat contribution per root, pad slots of a first beat masked off.
  always_comb begin
    sym_t d;
    d        = '0;
    beat_sum = '0;
    acc_next = '0;
    for (int j = 0; j < R; j++) begin
      for (int i = 0; i < P; i++) begin
        d = (bus.in_sop && i >= P - PAD) ? '0 : bus.data_in[i];
        beat_sum[j] = beat_sum[j] ^ gf_mul(d, TAP[j][i]);
      end
      acc_next[j] = gf_mul(acc[j], FB[j]) ^ beat_sum[j];
    end
  end

  // Framing FSM, accumulators and registered result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      syn_q   <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      if (bus.in_valid) begin
        if (bus.in_sop) begin
          ferr_q <= (state == ACC);
          acc    <= beat_sum;
          cnt    <= CW'(1);
          state  <= ACC;
        end else if (state == IDLE) begin
          ferr_q <= 1'b1;
        end else if (last_beat) begin
          valid_q <= 1'b1;
          syn_q   <= acc_next;
          zero_q  <= (acc_next == '0);
          acc     <= '0;
          cnt     <= '0;
          state   <= IDLE;
        end else begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  assign bus.syn_valid = valid_q;
  assign bus.syn_data  = syn_q;
  assign bus.syn_zero  = zero_q;
  assign bus.frm_err   = ferr_q;
endmodule

// File: tb/tb_dec_syndrome.sv
// Bench for dec_syndrome: random codewords against a
// direct polynomial-evaluation syndrome model.
module tb_dec_syndrome;
  localparam int N = 255;
  localparam int K = 239;
  localparam int R = N - K;
  localparam int P = 16;
  localparam int M = 8;
  localparam int BEATS = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dec_syndrome_if #(.M(M), .P(P), .R(R)) bus ();

  dec_syndrome #(
    .EGF_ORDER   (M),
    .EGF_PRIM_POL('h11D),
    .RS_COD_LEN  (N),
    .RS_MES_LEN  (K),
    .ENC_SYM_NUM (P),
    .FCR         (0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [7:0] alog [255];
  int         lg   [256];
  logic [7:0] gen  [17];
  logic [7:0] cw   [N];
  logic [7:0] tmp  [N];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int frm_cnt = 0;
  int last_edge = 0;
  int got_cyc = 0;
  int prev_cyc = 0;
  logic [127:0] got_data;
  logic         got_zero;

  logic [127:0] q_data [$];
  logic         q_zero [$];
  int           q_cyc  [$];
  logic [127:0] e_data [$];
  logic         e_zero [$];
  int           e_cyc  [$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.syn_valid) begin
      q_data.push_back(bus.syn_data);
      q_zero.push_back(bus.syn_zero);
      q_cyc.push_back(cyc);
    end
    if (bus.frm_err) frm_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return alog[(lg[a] + lg[b]) % 255];
  endfunction

  task automatic build_tables();
    int x;
    x = 1;
    for (int k = 0; k < 255; k++) begin
      alog[k] = 8'(x);
      lg[x] = k;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11D;
    end
    for (int t = 0; t < 17; t++) gen[t] = 8'h00;
    gen[0] = 8'h01;
    for (int j = 0; j < R; j++)
      for (int t = 16; t >= 0; t--)
        gen[t] = (t > 0 ? gen[t-1] : 8'h00) ^ gmul(gen[t], alog[j]);
  endtask

  task automatic clear_cw();
    for (int k = 0; k < N; k++) cw[k] = 8'h00;
  endtask

  task automatic rand_cw();
    for (int k = 0; k < N; k++) cw[k] = 8'($urandom);
  endtask

  task automatic encode_rand();
    logic [7:0] c;
    for (int k = 0; k < N; k++) cw[k] = (k < R) ? 8'h00 : 8'($urandom);
    for (int k = 0; k < N; k++) tmp[k] = cw[k];
    for (int k = N - 1; k >= R; k--) begin
      c = tmp[k];
      if (c != 8'h00)
        for (int t = 0; t <= R; t++)
          tmp[k-R+t] = tmp[k-R+t] ^ gmul(c, gen[t]);
    end
    for (int k = 0; k < R; k++) cw[k] = tmp[k];
  endtask

  task automatic inject(input int nerr);
    int pos [$];
    int p;
    bit dup;
    while (pos.size() < nerr) begin
      p = $urandom_range(N - 1);
      dup = 1'b0;
      foreach (pos[q]) if (pos[q] == p) dup = 1'b1;
      if (!dup) begin
        pos.push_back(p);
        cw[p] = cw[p] ^ 8'($urandom_range(255, 1));
      end
    end
  endtask

  task automatic push_expect();
    logic [127:0] v;
    logic [7:0] s;
    v = '0;
    for (int j = 0; j < R; j++) begin
      s = 8'h00;
      for (int k = 0; k < N; k++)
        s = s ^ gmul(cw[k], alog[(j * k) % 255]);
      v[j*8 +: 8] = s;
    end
    e_data.push_back(v);
    e_zero.push_back(v == '0);
    e_cyc.push_back(last_edge);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sop = 1'($urandom);
    for (int i = 0; i < P; i++) bus.data_in[i] = 8'($urandom);
  endtask

  task automatic send_beat(input int b, input bit sop, input bit garb);
    int deg;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sop = sop;
    for (int i = 0; i < P; i++) begin
      deg = (BEATS - 1 - b) * P + i;
      if (deg < N) bus.data_in[i] = cw[deg];
      else bus.data_in[i] = garb ? 8'($urandom) : 8'h00;
    end
    last_edge = cyc + 1;
  endtask

  task automatic send_cw(input int nb, input int gap, input bit garb);
    for (int b = 0; b < nb; b++) begin
      for (int g = 0; g < 3; g++)
        if (int'($urandom_range(99)) < gap) idle();
      send_beat(b, b == 0, garb);
    end
  endtask

  task automatic drain(input int n, input string tag);
    int t;
    for (int r = 0; r < n; r++) begin
      t = 0;
      while (q_data.size() == 0 && t < 64) begin
        @(posedge clk);
        t++;
      end
      if (q_data.size() == 0) begin
        chk({tag, "_timeout"}, 128'(0), 128'(1));
        return;
      end
      got_data = q_data.pop_front();
      got_zero = q_zero.pop_front();
      prev_cyc = got_cyc;
      got_cyc = q_cyc.pop_front();
      chk({tag, "_syn"}, got_data, e_data.pop_front());
      chk({tag, "_zero"}, 128'(got_zero), 128'(e_zero.pop_front()));
      chk({tag, "_lat"}, 128'(got_cyc), 128'(e_cyc.pop_front()));
    end
  endtask

  task automatic flush();
    q_data.delete();
    q_zero.delete();
    q_cyc.delete();
    e_data.delete();
    e_zero.delete();
    e_cyc.delete();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sop = 1'b0;
    bus.data_in = '0;
    build_tables();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 128'(bus.syn_valid), 128'(0));
    chk("rst_data", bus.syn_data, 128'(0));
    chk("rst_zero", 128'(bus.syn_zero), 128'(0));
    chk("rst_ferr", 128'(bus.frm_err), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    clear_cw();
    send_cw(BEATS, 0, 1'b0);
    push_expect();
    idle();
    drain(1, "allzero");
    chk("allzero_flag", 128'(got_zero), 128'(1));

    clear_cw();
    cw[0] = 8'h01;
    send_cw(BEATS, 0, 1'b0);
    push_expect();
    idle();
    drain(1, "deg0");
    chk("deg0_s15", 128'(got_data[127:120]), 128'(8'h01));

    clear_cw();
    cw[1] = 8'h01;
    send_cw(BEATS, 0, 1'b0);
    push_expect();
    idle();
    drain(1, "deg1");
    chk("deg1_s8", 128'(got_data[71:64]), 128'(8'h1d));
    chk("deg1_s4", 128'(got_data[39:32]), 128'(8'h10));

    encode_rand();
    send_cw(BEATS, 40, 1'b1);
    push_expect();
    idle();
    drain(1, "enc");
    chk("enc_flag", 128'(got_zero), 128'(1));
    inject(3);
    send_cw(BEATS, 40, 1'b1);
    push_expect();
    idle();
    drain(1, "err3");
    chk("err3_flag", 128'(got_zero), 128'(0));

    flush();
    frm_cnt = 0;
    rand_cw();
    send_cw(7, 0, 1'b0);
    clear_cw();
    send_cw(BEATS, 0, 1'b0);
    push_expect();
    idle();
    drain(1, "presop");
    repeat (20) @(posedge clk);
    chk("presop_ferr", 128'(frm_cnt), 128'(1));
    chk("presop_extra", 128'(q_data.size()), 128'(0));
    send_beat(3, 1'b0, 1'b0);
    idle();
    repeat (4) @(posedge clk);
    chk("drop_ferr", 128'(frm_cnt), 128'(2));
    chk("drop_extra", 128'(q_data.size()), 128'(0));

    flush();
    frm_cnt = 0;
    rand_cw();
    send_cw(9, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sop = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    encode_rand();
    inject(2);
    send_cw(BEATS, 20, 1'b1);
    push_expect();
    idle();
    drain(1, "rstmid");
    repeat (20) @(posedge clk);
    chk("rstmid_extra", 128'(q_data.size()), 128'(0));
    chk("rstmid_ferr", 128'(frm_cnt), 128'(0));

    flush();
    encode_rand();
    inject(1);
    send_cw(BEATS, 0, 1'b1);
    push_expect();
    encode_rand();
    send_cw(BEATS, 0, 1'b1);
    push_expect();
    idle();
    drain(2, "b2b");
    chk("b2b_gap", 128'(got_cyc - prev_cyc), 128'(BEATS));

    for (int n = 0; n < 12; n++) begin
      flush();
      encode_rand();
      inject($urandom_range(8));
      send_cw(BEATS, $urandom_range(50), 1'b1);
      push_expect();
      idle();
      drain(1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
